// File: rtl/crc_field_checker.sv
// rtl/crc_field_checker.sv - serial CRC field and delimiter checker for the receive path
module crc_field_checker #(
    parameter int CRC_WIDTH   = 15,
    parameter bit CHECK_DELIM = 1'b1,
    localparam int IDX_W      = $clog2(CRC_WIDTH)
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 bit_valid,
    input  logic                 rxd,
    input  logic [CRC_WIDTH-1:0] crc_calculated,
    output logic                 busy,
    output logic                 done,
    output logic                 crc_ok,
    output logic                 delim_err,
    output logic [IDX_W-1:0]     mismatch_idx
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CRC_WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COMPARE = 2'd1,
        S_DELIM   = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [CRC_WIDTH-1:0]   shadow_q, shadow_d;
    logic [IDX_W-1:0]       cnt_q, cnt_d;
    logic                   err_q, err_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   crc_ok_q, crc_ok_d;
    logic                   delim_err_q, delim_err_d;
    logic [IDX_W-1:0]       idx_q, idx_d;

    // The shadow shifts left per compared bit, so its MSB is always the bit under test.
    logic bit_mismatch;
    assign bit_mismatch = rxd ^ shadow_q[CRC_WIDTH-1];

    always_comb begin
        state_d     = state_q;
        shadow_d    = shadow_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        crc_ok_d    = crc_ok_q;
        delim_err_d = delim_err_q;
        idx_d       = idx_q;

        if (abort) begin
            state_d     = S_IDLE;
            shadow_d    = '0;
            cnt_d       = '0;
            err_d       = 1'b0;
            busy_d      = 1'b0;
            crc_ok_d    = 1'b0;
            delim_err_d = 1'b0;
            idx_d       = '0;
        end else if (start) begin
            state_d     = S_COMPARE;
            shadow_d    = crc_calculated;
            cnt_d       = '0;
            err_d       = 1'b0;
            busy_d      = 1'b1;
            crc_ok_d    = 1'b0;
            delim_err_d = 1'b0;
            idx_d       = '0;
        end else begin
            case (state_q)
                S_COMPARE: begin
                    if (bit_valid) begin
                        shadow_d = {shadow_q[CRC_WIDTH-2:0], 1'b0};
                        if (bit_mismatch && !err_q) begin
                            idx_d = cnt_q;
                        end
                        err_d = err_q | bit_mismatch;
                        if (cnt_q == LAST_IDX) begin
                            if (CHECK_DELIM) begin
                                state_d = S_DELIM;
                            end else begin
                                state_d  = S_DONE;
                                busy_d   = 1'b0;
                                done_d   = 1'b1;
                                crc_ok_d = ~(err_q | bit_mismatch);
                            end
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                S_DELIM: begin
                    if (bit_valid) begin
                        state_d     = S_DONE;
                        busy_d      = 1'b0;
                        done_d      = 1'b1;
                        delim_err_d = ~rxd;
                        crc_ok_d    = ~err_q & rxd;
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= S_IDLE;
            shadow_q    <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            crc_ok_q    <= 1'b0;
            delim_err_q <= 1'b0;
            idx_q       <= '0;
        end else begin
            state_q     <= state_d;
            shadow_q    <= shadow_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            crc_ok_q    <= crc_ok_d;
            delim_err_q <= delim_err_d;
            idx_q       <= idx_d;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign crc_ok       = crc_ok_q;
    assign delim_err    = delim_err_q;
    assign mismatch_idx = idx_q;

endmodule
